cfa_bilinear_interp: RTL and testbench

// - Downstream stage of buffer_2d_v3 in the CFA demosaic datapath.
// - Consumes one 3-plane 3x3 window and the R/B row flag per enabled cycle; emits one full RGB pixel per window.
// - Input planes are sparse Bayer planes (RGGB): ch0=R, ch1=G, ch2=B; absent sites carry 0.
// - Bilinear interpolation is done in a 3-stage pipeline. Position is tracked by raster counters.

---
 rtl/cfa_bilinear_interp.sv | 208 ++++++++++++++++++++
 tb/tb_cfa_bilinear_interp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfa_bilinear_interp.sv
// Bilinear RGGB demosaic stage: one 3-plane 3x3 window in, one RGB pixel out, 3-cycle pipeline.
// Build option: define CFA_ROUND_EN for round-half-up averaging (default is truncation).
module cfa_bilinear_interp #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [215:0] buffer_data,
  input  logic         RB_interpolation,
  output logic [23:0]  rgb_out,
  output logic         out_valid,
  output logic         frame_done,
  output logic         phase_err
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

`ifdef CFA_ROUND_EN
  localparam int unsigned RND4 = 2;
  localparam int unsigned RND2 = 1;
`else
  localparam int unsigned RND4 = 0;
  localparam int unsigned RND2 = 0;
`endif

  typedef enum logic [1:0] {SITE_R, SITE_GR, SITE_GB, SITE_B} site_t;

  function automatic logic [7:0] pix(input logic [215:0] w, input int unsigned c,
                                     input int unsigned r, input int unsigned k);
    return w[(c*9 + r*3 + k)*8 +: 8];
  endfunction

  function automatic logic [7:0] div4(input logic [9:0] s);
    return 8'((s + 10'(RND4)) >> 2);
  endfunction

  function automatic logic [7:0] div2(input logic [8:0] s);
    return 8'((s + 9'(RND2)) >> 1);
  endfunction

  // Raster position
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          phase_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Stage 1
  logic [215:0] win1_q;
  site_t        site1_q, site1_d;
  logic         border1_q, last1_q, v1_q;
  logic         border1_d, last1_d;

  always_comb begin
    case ({row_q[0], col_q[0]})
      2'b00:   site1_d = SITE_R;
      2'b01:   site1_d = SITE_GR;
      2'b10:   site1_d = SITE_GB;
      default: site1_d = SITE_B;
    endcase
    border1_d = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
    last1_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      phase_q   <= 1'b0;
      win1_q    <= '0;
      site1_q   <= SITE_R;
      border1_q <= 1'b0;
      last1_q   <= 1'b0;
      v1_q      <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= en;
      // Row 0 is R/G, so the flag must be high exactly on even rows
      if (en && (RB_interpolation != ~row_q[0])) phase_q <= 1'b1;
      if (en) begin
        win1_q    <= buffer_data;
        site1_q   <= site1_d;
        border1_q <= border1_d;
        last1_q   <= last1_d;
      end
    end
  end

  // The green plane's diagonal samples are never needed by any site type
  logic unused_ch1_diag;
  assign unused_ch1_diag = ^{pix(win1_q, 1, 0, 0), pix(win1_q, 1, 0, 2),
                             pix(win1_q, 1, 2, 0), pix(win1_q, 1, 2, 2)};

  // Stage 2: neighbour sums
  logic [9:0] orth_d, diag_d, raw_sum;
  logic [8:0] s2r_d, s2b_d;
  logic [7:0] raw_d;
  int unsigned dpl;

  always_comb begin
    orth_d = 10'(pix(win1_q, 1, 0, 1)) + 10'(pix(win1_q, 1, 2, 1)) +
             10'(pix(win1_q, 1, 1, 0)) + 10'(pix(win1_q, 1, 1, 2));
    dpl    = (site1_q == SITE_B) ? 0 : 2;
    diag_d = 10'(pix(win1_q, dpl, 0, 0)) + 10'(pix(win1_q, dpl, 0, 2)) +
             10'(pix(win1_q, dpl, 2, 0)) + 10'(pix(win1_q, dpl, 2, 2));
    if (site1_q == SITE_GR) begin
      s2r_d = 9'(pix(win1_q, 0, 1, 0)) + 9'(pix(win1_q, 0, 1, 2));
      s2b_d = 9'(pix(win1_q, 2, 0, 1)) + 9'(pix(win1_q, 2, 2, 1));
    end else begin
      s2r_d = 9'(pix(win1_q, 0, 0, 1)) + 9'(pix(win1_q, 0, 2, 1));
      s2b_d = 9'(pix(win1_q, 2, 1, 0)) + 9'(pix(win1_q, 2, 1, 2));
    end
    raw_sum = 10'(pix(win1_q, 0, 1, 1)) + 10'(pix(win1_q, 1, 1, 1)) + 10'(pix(win1_q, 2, 1, 1));
    raw_d   = (raw_sum > 10'd255) ? 8'hFF : raw_sum[7:0];
  end

  logic [9:0] orth_q, diag_q;
  logic [8:0] s2r_q, s2b_q;
  logic [7:0] c0_q, c1_q, c2_q, raw_q;
  site_t      site2_q;
  logic       border2_q, last2_q, v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      orth_q    <= '0;
      diag_q    <= '0;
      s2r_q     <= '0;
      s2b_q     <= '0;
      c0_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      raw_q     <= '0;
      site2_q   <= SITE_R;
      border2_q <= 1'b0;
      last2_q   <= 1'b0;
      v2_q      <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        orth_q    <= orth_d;
        diag_q    <= diag_d;
        s2r_q     <= s2r_d;
        s2b_q     <= s2b_d;
        c0_q      <= pix(win1_q, 0, 1, 1);
        c1_q      <= pix(win1_q, 1, 1, 1);
        c2_q      <= pix(win1_q, 2, 1, 1);
        raw_q     <= raw_d;
        site2_q   <= site1_q;
        border2_q <= border1_q;
        last2_q   <= last1_q;
      end
    end
  end

  // Stage 3: divide/select
  logic [7:0] r_s, g_s, b_s;

  always_comb begin
    r_s = raw_q;
    g_s = raw_q;
    b_s = raw_q;
    if (!border2_q) begin
      case (site2_q)
        SITE_R:  begin r_s = c0_q;         g_s = div4(orth_q); b_s = div4(diag_q); end
        SITE_B:  begin r_s = div4(diag_q); g_s = div4(orth_q); b_s = c2_q;         end
        default: begin r_s = div2(s2r_q);  g_s = c1_q;         b_s = div2(s2b_q);  end
      endcase
    end
  end

  logic [23:0] rgb_q;
  logic        valid_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= v2_q;
      done_q  <= v2_q && last2_q;
      if (v2_q) rgb_q <= {b_s, g_s, r_s};
    end
  end

  assign rgb_out    = rgb_q;
  assign out_valid  = valid_q;
  assign frame_done = done_q;
  assign phase_err  = phase_q;

endmodule

// File: tb/tb_cfa_bilinear_interp.sv
// Self-checking bench for cfa_bilinear_interp on a 4x4 frame: directed table plus image-based reference model.
module tb_cfa_bilinear_interp;

  localparam int W = 4;
  localparam int H = 4;
`ifdef CFA_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic         clk, rst, en, RB_interpolation;
  logic [215:0] buffer_data;
  logic [23:0]  rgb_out;
  logic         out_valid, frame_done, phase_err;

  cfa_bilinear_interp #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .en(en), .buffer_data(buffer_data),
    .RB_interpolation(RB_interpolation), .rgb_out(rgb_out),
    .out_valid(out_valid), .frame_done(frame_done), .phase_err(phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [215:0] win;
    logic [23:0]  exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int brow = 0, bcol = 0;
  int nv = 0, nfd = 0;
  logic ph = 1'b0;
  logic [23:0] held = '0;
  logic        exp_v  [0:4095];
  logic        exp_fd [0:4095];
  logic [23:0] exp_rgb[0:4095];
  int img[0:H+1][0:W+1];
  vec_t tbl[16];

  function automatic logic [215:0] sb(input logic [215:0] w, input int c, input int r,
                                      input int k, input logic [7:0] v);
    logic [215:0] t;
    t = w;
    t[(c*9 + r*3 + k)*8 +: 8] = v;
    return t;
  endfunction

  function automatic logic [7:0] gb(input logic [215:0] w, input int c, input int r, input int k);
    return w[(c*9 + r*3 + k)*8 +: 8];
  endfunction

  function automatic logic [215:0] ctr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [215:0] t;
    t = '0;
    t = sb(t, 0, 1, 1, a);
    t = sb(t, 1, 1, 1, b);
    t = sb(t, 2, 1, 1, c);
    return t;
  endfunction

  // RGGB colour present at absolute sensor position (r,c)
  function automatic int plane_of(input int r, input int c);
    int pr, pc;
    pr = ((r % 2) + 2) % 2;
    pc = ((c % 2) + 2) % 2;
    if (pr == 0 && pc == 0) return 0;
    if (pr == 1 && pc == 1) return 2;
    return 1;
  endfunction

  // Average of every sample of colour ch present in the window (or the centre if it is that colour)
  function automatic logic [7:0] avg_ch(input logic [215:0] w, input int row, input int col, input int ch);
    int sum, cnt;
    if (plane_of(row, col) == ch) return gb(w, ch, 1, 1);
    sum = 0;
    cnt = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (plane_of(row + dr - 1, col + dc - 1) == ch) begin
          sum += int'(gb(w, ch, dr, dc));
          cnt++;
        end
    if (RND != 0) return 8'((sum + cnt / 2) / cnt);
    return 8'(sum / cnt);
  endfunction

  function automatic logic [23:0] model(input logic [215:0] w, input int row, input int col);
    int raw;
    if (row == 0 || row == H - 1 || col == 0 || col == W - 1) begin
      raw = int'(gb(w, 0, 1, 1)) + int'(gb(w, 1, 1, 1)) + int'(gb(w, 2, 1, 1));
      if (raw > 255) raw = 255;
      return {8'(raw), 8'(raw), 8'(raw)};
    end
    return {avg_ch(w, row, col, 2), avg_ch(w, row, col, 1), avg_ch(w, row, col, 0)};
  endfunction

  // Window around (row,col) of the sensor image; absent colours are zero or random junk
  function automatic logic [215:0] mk_win(input int row, input int col, input logic junk);
    logic [215:0] t;
    int p;
    t = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        p = plane_of(row + dr - 1, col + dc - 1);
        for (int ch = 0; ch < 3; ch++)
          if (ch == p) t = sb(t, ch, dr, dc, 8'(img[row + dr][col + dc]));
          else if (junk) t = sb(t, ch, dr, dc, 8'($urandom_range(255)));
      end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic step(input logic e, input logic [215:0] w, input logic bad_rb,
                      input logic r, input logic use_tbl, input logic [23:0] texp);
    logic efd;
    en = e;
    buffer_data = w;
    RB_interpolation = ((brow % 2) == 0) ^ bad_rb;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      exp_v[cyc] = 1'b0;
      exp_v[cyc + 1] = 1'b0;
      held = '0;
      ph = 1'b0;
      brow = 0;
      bcol = 0;
    end else begin
      if (e) begin
        exp_v[cyc + 2]   = 1'b1;
        exp_rgb[cyc + 2] = use_tbl ? texp : model(w, brow, bcol);
        exp_fd[cyc + 2]  = (brow == H - 1) && (bcol == W - 1);
        if (bad_rb) ph = 1'b1;
        if (bcol == W - 1) begin
          bcol = 0;
          brow = (brow == H - 1) ? 0 : brow + 1;
        end else begin
          bcol++;
        end
      end
      if (exp_v[cyc]) held = exp_rgb[cyc];
    end
    #1;
    efd = exp_v[cyc] && exp_fd[cyc];
    chk("out_valid", 32'(out_valid), 32'(exp_v[cyc]));
    chk("frame_done", 32'(frame_done), 32'(efd));
    chk("rgb_out", 32'(rgb_out), 32'(held));
    chk("phase_err", 32'(phase_err), 32'(ph));
    if (out_valid) nv++;
    if (frame_done) nfd++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic fill_img(input int flat);
    for (int r = 0; r < H + 2; r++)
      for (int c = 0; c < W + 2; c++)
        img[r][c] = (flat >= 0) ? flat : int'($urandom_range(255));
  endtask

  task automatic send_pos(input int p, input logic junk, input int bubble_pct);
    while (int'($urandom_range(99)) < bubble_pct)
      step(1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, mk_win(p / W, p % W, junk), 1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [215:0] w;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      exp_v[i] = 1'b0;
      exp_fd[i] = 1'b0;
      exp_rgb[i] = '0;
    end
    en = 1'b0;
    rst = 1'b1;
    RB_interpolation = 1'b1;
    buffer_data = '0;

    // Directed frame: borders, saturation and every interior site type
    for (int i = 0; i < 16; i++) tbl[i] = '{win: '0, exp: '0};
    tbl[0]  = '{win: ctr(77, 0, 0),    exp: {8'd77, 8'd77, 8'd77}};
    tbl[1]  = '{win: ctr(200, 100, 0), exp: {8'd255, 8'd255, 8'd255}};
    tbl[2]  = '{win: ctr(10, 20, 30),  exp: {8'd60, 8'd60, 8'd60}};
    tbl[3]  = '{win: ctr(0, 0, 0),     exp: {8'd0, 8'd0, 8'd0}};
    tbl[4]  = '{win: ctr(0, 0, 255),   exp: {8'd255, 8'd255, 8'd255}};
    w = ctr(5, 99, 90);
    w = sb(w, 1, 0, 1, 1);  w = sb(w, 1, 2, 1, 2);  w = sb(w, 1, 1, 0, 3);  w = sb(w, 1, 1, 2, 4);
    w = sb(w, 1, 0, 0, 99); w = sb(w, 1, 2, 2, 99);
    w = sb(w, 0, 0, 0, 7);  w = sb(w, 0, 0, 2, 8);  w = sb(w, 0, 2, 0, 9);  w = sb(w, 0, 2, 2, 10);
    tbl[5]  = '{win: w, exp: {8'd90, 8'(RND != 0 ? 3 : 2), 8'(RND != 0 ? 9 : 8)}};
    w = ctr(0, 123, 0);
    w = sb(w, 0, 0, 1, 11); w = sb(w, 0, 2, 1, 12); w = sb(w, 0, 1, 0, 250); w = sb(w, 0, 1, 2, 250);
    w = sb(w, 2, 1, 0, 40); w = sb(w, 2, 1, 2, 41); w = sb(w, 2, 0, 1, 250); w = sb(w, 2, 2, 1, 250);
    tbl[6]  = '{win: w, exp: {8'(RND != 0 ? 41 : 40), 8'd123, 8'(RND != 0 ? 12 : 11)}};
    tbl[7]  = '{win: ctr(1, 1, 1),     exp: {8'd3, 8'd3, 8'd3}};
    tbl[8]  = '{win: ctr(255, 255, 255), exp: {8'd255, 8'd255, 8'd255}};
    w = ctr(0, 45, 0);
    w = sb(w, 0, 1, 0, 50); w = sb(w, 0, 1, 2, 51); w = sb(w, 0, 0, 1, 250); w = sb(w, 0, 2, 1, 250);
    w = sb(w, 2, 0, 1, 60); w = sb(w, 2, 2, 1, 80); w = sb(w, 2, 1, 0, 250); w = sb(w, 2, 1, 2, 250);
    tbl[9]  = '{win: w, exp: {8'd70, 8'd45, 8'(RND != 0 ? 51 : 50)}};
    w = ctr(33, 0, 0);
    w = sb(w, 1, 0, 1, 10); w = sb(w, 1, 2, 1, 20); w = sb(w, 1, 1, 0, 30); w = sb(w, 1, 1, 2, 42);
    w = sb(w, 1, 0, 0, 250); w = sb(w, 0, 0, 1, 250);
    w = sb(w, 2, 0, 0, 200); w = sb(w, 2, 0, 2, 200); w = sb(w, 2, 2, 0, 200); w = sb(w, 2, 2, 2, 200);
    tbl[10] = '{win: w, exp: {8'd200, 8'(RND != 0 ? 26 : 25), 8'd33}};
    tbl[11] = '{win: ctr(100, 100, 100), exp: {8'd255, 8'd255, 8'd255}};
    tbl[12] = '{win: ctr(128, 127, 0), exp: {8'd255, 8'd255, 8'd255}};
    tbl[13] = '{win: ctr(0, 0, 1),     exp: {8'd1, 8'd1, 8'd1}};
    tbl[14] = '{win: ctr(254, 0, 0),   exp: {8'd254, 8'd254, 8'd254}};
    tbl[15] = '{win: ctr(5, 6, 7),     exp: {8'd18, 8'd18, 8'd18}};

    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(2);

    for (int i = 0; i < 16; i++) step(1'b1, tbl[i].win, 1'b0, 1'b0, 1'b1, tbl[i].exp);
    idle(3);

    // Flat field
    fill_img(100);
    nv = 0;
    nfd = 0;
    for (int p = 0; p < 16; p++) send_pos(p, 1'b0, 0);
    idle(3);
    chk("flat_out_count", 32'(nv), 32'd16);
    chk("flat_frame_done_count", 32'(nfd), 32'd1);

    // Random images with junk in absent planes and random bubbles
    for (int f = 0; f < 3; f++) begin
      fill_img(-1);
      for (int p = 0; p < 16; p++) send_pos(p, 1'b1, 30);
    end
    idle(3);

    // Mid-frame reset in the slot of window 7
    fill_img(-1);
    nv = 0;
    for (int p = 0; p < 7; p++) send_pos(p, 1'b1, 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(3);
    chk("outputs_before_reset", 32'(nv), 32'd5);
    fill_img(-1);
    nv = 0;
    nfd = 0;
    for (int p = 0; p < 16; p++) send_pos(p, 1'b1, 20);
    idle(3);
    chk("post_reset_out_count", 32'(nv), 32'd16);
    chk("post_reset_frame_done_count", 32'(nfd), 32'd1);

    // Phase error on a row-0 window is sticky until reset
    step(1'b1, ctr(9, 0, 0), 1'b1, 1'b0, 1'b0, '0);
    for (int p = 1; p < 6; p++) send_pos(p, 1'b1, 0);
    idle(3);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
